// File: rtl/dcache_array_nway.sv
// N-way set-associative D-cache storage array with tree-PLRU replacement,
// a registered one-cycle lookup response and a write-back flush engine.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/ready/op/addr  request handshake; op 00 rd, 01 wr, 10 fill
//   req_be, req_data         write byte enables, write/fill block
//   rsp_*                    response registered one cycle after accept
//   flush_start, flush_busy  clean-and-invalidate of the whole array
//   wb_valid/ready/addr/data dirty-line write-back port used by the flush
module dcache_array_nway #(
    parameter int SETS        = 32,
    parameter int WAYS        = 2,
    parameter int BLOCK_BYTES = 16,
    parameter int TAG_W       = 22,
    localparam int IDX_W      = $clog2(SETS),
    localparam int ADDR_W     = TAG_W + IDX_W,
    localparam int BLK_W      = 8 * BLOCK_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [BLOCK_BYTES-1:0] req_be,
    input  logic [BLK_W-1:0]       req_data,
    output logic                   rsp_valid,
    output logic                   rsp_hit,
    output logic [BLK_W-1:0]       rsp_data,
    output logic                   rsp_victim_dirty,
    output logic [TAG_W-1:0]       rsp_victim_tag,
    output logic [BLK_W-1:0]       rsp_victim_data,
    input  logic                   flush_start,
    output logic                   flush_busy,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [ADDR_W-1:0]      wb_addr,
    output logic [BLK_W-1:0]       wb_data
);

    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = IDX_W + WAY_W;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WB} state_t;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAYS-2:0]  plru_q  [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [BLK_W-1:0] data_q  [SETS][WAYS];

    state_t state, state_n;
    logic [LINE_W-1:0] line_q;
    logic [IDX_W-1:0]  f_set;
    logic [WAY_W-1:0]  f_way;
    logic line_dirty, line_clear, flush_done;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic is_write, is_fill, acc;
    logic hit, any_inv;
    logic [WAY_W-1:0] hit_way, inv_way, victim_way, touch_way;
    logic [WAYS-2:0] plru_new;
    logic [BLK_W-1:0] merged, wr_block;

    // Walk the tree from the root: a 0 bit points at the lower half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] t);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] way;
        logic b;
        node = '0;
        way  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b    = t[node];
            way  = (way << 1) | WAY_W'(b);
            node = (node << 1) + WAY_W'(1) + WAY_W'(b);
        end
        return way;
    endfunction

    // Point every node on the path away from the touched way.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                   input logic [WAY_W-1:0] w);
        logic [WAYS-2:0] r;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] ww;
        logic b;
        r    = t;
        node = '0;
        ww   = w;
        for (int l = 0; l < WAY_W; l++) begin
            b       = ww[WAY_W-1];
            r[node] = !b;
            node    = (node << 1) + WAY_W'(1) + WAY_W'(b);
            ww      = ww << 1;
        end
        return r;
    endfunction

    assign idx      = req_addr[IDX_W-1:0];
    assign tag      = req_addr[ADDR_W-1:IDX_W];
    assign is_write = (req_op == 2'b01);
    assign is_fill  = (req_op == 2'b10);
    assign acc      = req_valid && req_ready;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign victim_way = any_inv ? inv_way : plru_victim(plru_q[idx]);
    assign touch_way  = hit ? hit_way : victim_way;
    assign plru_new   = plru_touch(plru_q[idx], touch_way);

    always_comb begin
        merged = data_q[idx][hit_way];
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (req_be[i]) merged[8*i +: 8] = req_data[8*i +: 8];
        end
        wr_block = is_fill ? req_data : merged;
    end

    // Flush line pointer: way in the low bits so ways advance fastest.
    assign f_set      = line_q[LINE_W-1:WAY_W];
    assign f_way      = line_q[WAY_W-1:0];
    assign line_dirty = valid_q[f_set][f_way] && dirty_q[f_set][f_way];
    assign line_clear = (state == S_SCAN && !line_dirty) ||
                        (state == S_WB && wb_ready);
    assign flush_done = line_clear && (&line_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (flush_start) state_n = S_SCAN;
            S_SCAN: begin
                if (line_dirty)   state_n = S_WB;
                else if (&line_q) state_n = S_IDLE;
            end
            S_WB: if (wb_ready) state_n = (&line_q) ? S_IDLE : S_SCAN;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        flush_busy = (state != S_IDLE);
        wb_valid   = (state == S_WB);
        req_ready  = (state == S_IDLE) && !flush_start;
        wb_addr    = '0;
        wb_data    = '0;
        if (state == S_WB) begin
            wb_addr = {tag_q[f_set][f_way], f_set};
            wb_data = data_q[f_set][f_way];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 line_q <= '0;
        else if (state == S_IDLE) line_q <= '0;
        else if (line_clear)      line_q <= line_q + LINE_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (acc) begin
                if (hit) begin
                    if (is_write) dirty_q[idx][hit_way] <= 1'b1;
                    if (is_fill)  dirty_q[idx][hit_way] <= 1'b0;
                    if (!is_fill) plru_q[idx] <= plru_new;
                end else if (is_fill) begin
                    valid_q[idx][victim_way] <= 1'b1;
                    dirty_q[idx][victim_way] <= 1'b0;
                    plru_q[idx]              <= plru_new;
                end
            end
            if (line_clear) begin
                valid_q[f_set][f_way] <= 1'b0;
                dirty_q[f_set][f_way] <= 1'b0;
            end
            if (flush_done) begin
                for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (acc && is_fill && !hit) tag_q[idx][victim_way] <= tag;
        if (acc && (is_fill || (is_write && hit)))
            data_q[idx][touch_way] <= wr_block;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_data         <= '0;
            rsp_victim_dirty <= 1'b0;
            rsp_victim_tag   <= '0;
            rsp_victim_data  <= '0;
        end else begin
            rsp_valid <= acc;
            if (acc) begin
                rsp_hit          <= hit;
                rsp_data         <= hit ? data_q[idx][hit_way] : '0;
                rsp_victim_dirty <= !hit && valid_q[idx][victim_way] &&
                                    dirty_q[idx][victim_way];
                rsp_victim_tag   <= tag_q[idx][victim_way];
                rsp_victim_data  <= data_q[idx][victim_way];
            end
        end
    end

endmodule
